// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU byte-stream front end: operation codes
//   understood by the ALU, a helper that says whether a code is supported,
//   and the front-end FSM state encoding.
package alu_pkg;

    localparam int OP_WIDTH = 6;

    localparam logic [OP_WIDTH-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_WIDTH-1:0] OP_AND = 6'b100100;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_WIDTH-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_WIDTH-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_WIDTH-1:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

    function automatic logic op_is_valid(input logic [OP_WIDTH-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_interface.sv
// alu_interface
//   Collects operand A, operand B and an op code from a received byte stream,
//   presents them (registered) to an external combinational ALU, captures the
//   result and offers it to a transmitter over a valid/ready handshake.
//
//   Ports
//     i_clk, i_reset      clock, synchronous active-high reset
//     i_rx_data/valid     received byte and its one-cycle strobe
//     o_alu_A/B/op        registered operands and op code to the ALU
//     i_alu_result        combinational ALU result
//     o_tx_data/valid     result byte to transmitter, held until accepted
//     i_tx_ready          transmitter accept
//     o_op_invalid        last captured op code is not a supported operation
//     o_rx_drop           one-cycle pulse: a byte arrived while busy
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_GET_A  | waiting for operand A byte
//   ST_GET_B  | waiting for operand B byte
//   ST_GET_OP | waiting for op-code byte
//   ST_EXEC   | ALU inputs settled; capture result this cycle
//   ST_SEND   | result offered to transmitter until accepted
module alu_interface
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MODE_WIDTH = OP_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_alu_A,
    output logic [DATA_WIDTH-1:0] o_alu_B,
    output logic [MODE_WIDTH-1:0] o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_op_invalid,
    output logic                  o_rx_drop
);

    state_t state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_GET_A;
            o_alu_A      <= '0;
            o_alu_B      <= '0;
            o_alu_op     <= '0;
            o_tx_data    <= '0;
            o_tx_valid   <= 1'b0;
            o_op_invalid <= 1'b0;
            o_rx_drop    <= 1'b0;
        end else begin
            o_rx_drop <= 1'b0;
            case (state)
                ST_GET_A: begin
                    if (i_rx_valid) begin
                        o_alu_A <= i_rx_data;
                        state   <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (i_rx_valid) begin
                        o_alu_B <= i_rx_data;
                        state   <= ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (i_rx_valid) begin
                        // Upper bits of the op byte are ignored; unsupported
                        // codes still execute (ALU returns zero).
                        o_alu_op     <= i_rx_data[MODE_WIDTH-1:0];
                        o_op_invalid <= !op_is_valid(i_rx_data[MODE_WIDTH-1:0]);
                        state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    o_rx_drop  <= i_rx_valid;
                    o_tx_data  <= i_alu_result;
                    o_tx_valid <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    o_rx_drop <= i_rx_valid;
                    if (o_tx_valid && i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        state      <= ST_GET_A;
                    end
                end
                default: begin
                    state <= ST_GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_interface.sv
module tb_alu_interface;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       op_invalid;
    logic       rx_drop;

    int tests;
    int failed;

    alu_interface #(.DATA_WIDTH(8), .MODE_WIDTH(6)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_alu_A      (alu_a),
        .o_alu_B      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_op_invalid (op_invalid),
        .o_rx_drop    (rx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: shifts move by one position, unknown codes give zero.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return {a[7], a[7:1]};
            6'h02:   return {1'b0, a[7:1]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic ref_invalid(input logic [7:0] op_byte);
        logic [5:0] op;
        op = op_byte[5:0];
        return !(op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02});
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge with rx_valid low, FSM in GET_A.
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [7:0] exp_data, input int stall, input bit drop);
        logic inv;
        inv      = ref_invalid(opb);
        tx_ready = (stall == 0);
        rx_data  = a;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_data = b;
        @(negedge clk);
        rx_data = opb;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_op", alu_op, opb[5:0]);
        chk("op_invalid", op_invalid, inv);
        chk("tx_valid_exec", tx_valid, 1'b0);
        chk("rx_drop_accept", rx_drop, 1'b0);
        @(negedge clk);
        chk("tx_valid_send", tx_valid, 1'b1);
        chk("tx_data", tx_data, exp_data);
        for (int i = 0; i < stall; i++) begin
            if (drop && i == 0) begin
                rx_data  = 8'h11;
                rx_valid = 1'b1;
            end
            @(negedge clk);
            rx_valid = 1'b0;
            chk("tx_valid_hold", tx_valid, 1'b1);
            chk("tx_data_hold", tx_data, exp_data);
            chk("rx_drop", rx_drop, (drop && i == 0));
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("tx_valid_after", tx_valid, 1'b0);
        chk("op_invalid_stable", op_invalid, inv);
    endtask

    initial begin
        logic [7:0] a, b, opb;
        logic [7:0] valid_ops [8];
        int stall;
        bit drop;

        valid_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        tests    = 0;
        failed   = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_alu_op", alu_op, 6'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_op_invalid", op_invalid, 1'b0);
        chk("rst_rx_drop", rx_drop, 1'b0);
        reset = 1'b0;

        do_txn(8'h05, 8'h03, 8'h20, 8'h08, 0, 0);
        do_txn(8'h03, 8'h05, 8'h22, 8'hFE, 0, 0);
        do_txn(8'h80, 8'h00, 8'h03, 8'hC0, 0, 0);
        do_txn(8'h80, 8'h00, 8'h02, 8'h40, 0, 0);
        do_txn(8'h12, 8'h34, 8'h25, 8'h36, 10, 1);
        do_txn(8'h0F, 8'hF0, 8'h27, 8'h00, 0, 0);
        do_txn(8'h55, 8'h66, 8'hFF, 8'h00, 0, 0);
        do_txn(8'h0A, 8'h0B, 8'h26, 8'h01, 0, 0);
        do_txn(8'h01, 8'h02, 8'hE0, 8'h03, 0, 0);

        // Reset with A and B already captured.
        rx_data  = 8'h05;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_data = 8'h03;
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_alu_a", alu_a, 8'h00);
        chk("mid_rst_alu_b", alu_b, 8'h00);
        chk("mid_rst_alu_op", alu_op, 6'h00);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_op_invalid", op_invalid, 1'b0);
        @(negedge clk);
        chk("post_rst_alu_a", alu_a, 8'h00);
        chk("post_rst_tx_valid", tx_valid, 1'b0);
        do_txn(8'h07, 8'h01, 8'h24, 8'h01, 0, 0);

        // Reset while a result is pending in SEND.
        tx_ready = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h09;
        @(negedge clk);
        rx_data = 8'h04;
        @(negedge clk);
        rx_data = 8'h20;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("pend_tx_valid", tx_valid, 1'b1);
        chk("pend_tx_data", tx_data, 8'h0D);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("send_rst_tx_valid", tx_valid, 1'b0);
        chk("send_rst_tx_data", tx_data, 8'h00);
        tx_ready = 1'b1;
        do_txn(8'h10, 8'h20, 8'h26, 8'h30, 0, 0);

        for (int n = 0; n < 30; n++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            opb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : valid_ops[$urandom_range(0, 7)];
            stall = $urandom_range(0, 3);
            drop  = (stall > 0) && ($urandom_range(0, 1) == 1);
            do_txn(a, b, opb, ref_alu(a, b, opb[5:0]), stall, drop);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
